// File: rtl/audio_meter_pkg.sv
// Shared definitions for the audio level meter.
//   - Meter FSM state encoding
//   - Datapath widths and the full-scale magnitude value
//   - scale_sat(): peak-to-level scaling with 8-bit saturation
package audio_meter_pkg;

  localparam int PEAK_W  = 15;
  localparam int LEVEL_W = 8;
  localparam logic [PEAK_W-1:0] FULL_SCALE = 15'h7FFF;

  // ST_ prefix keeps these names clear of the DECAY parameter on the top level.
  typedef enum logic [1:0] {
    ST_ACCUM,
    ST_SCALE,
    ST_DECAY
  } meter_state_e;

  // Right-shift the frame peak and clamp anything that no longer fits in 8 bits.
  function automatic logic [LEVEL_W-1:0] scale_sat(input logic [PEAK_W-1:0] peak,
                                                   input int shift);
    logic [PEAK_W-1:0] s;
    s = peak >> shift;
    if (|s[PEAK_W-1:LEVEL_W]) scale_sat = '1;
    else                      scale_sat = s[LEVEL_W-1:0];
  endfunction

endpackage

// File: rtl/sync_edge_det.sv
// N-flop synchronizer with a registered falling-edge pulse.
// All flops reset to 1 so a line idling high never produces a false edge
// when reset is released.
// Ports:
//   clk_i   - destination clock
//   rst_ni  - asynchronous active-low reset
//   d_i     - asynchronous input
//   fall_o  - one-cycle pulse, N+1 cycles after a 1->0 transition on d_i
module sync_edge_det #(
  parameter int N = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic fall_o
);

  logic [N-1:0] sync_q;
  logic         prev_q;
  logic         fall_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '1;
      prev_q <= 1'b1;
      fall_q <= 1'b0;
    end else begin
      sync_q[0] <= d_i;
      for (int i = 1; i < N; i++) sync_q[i] <= sync_q[i-1];
      prev_q <= sync_q[N-1];
      fall_q <= prev_q & ~sync_q[N-1];
    end
  end

  assign fall_o = fall_q;

endmodule

// File: rtl/audio_level_meter.sv
// Per-frame audio level meter feeding the waveform overlay.
// Tracks the absolute peak of the signed 16-bit sample stream over each video
// frame; on the falling edge of vsync the peak is scaled to 8 bits and merged
// with the previous level under peak-hold / linear-decay ballistics.
// Ports:
//   clk_sys    - system/audio clock
//   reset_n    - asynchronous active-low reset
//   sample_in  - signed audio sample, qualified by sample_stb
//   sample_stb - one-cycle sample qualifier
//   vsync      - active-low video vsync, asynchronous to clk_sys
//   en         - meter enable; when low the level only decays
//   level      - per-frame display level
//   level_stb  - one-cycle pulse when level updates
//   clip       - set for the frame following a full-scale sample
module audio_level_meter
  import audio_meter_pkg::*;
#(
  parameter int SHIFT       = 7,
  parameter int DECAY       = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk_sys,
  input  logic                reset_n,
  input  logic [15:0]         sample_in,
  input  logic                sample_stb,
  input  logic                vsync,
  input  logic                en,
  output logic [LEVEL_W-1:0]  level,
  output logic                level_stb,
  output logic                clip
);

  localparam logic [LEVEL_W-1:0] DECAY_L = LEVEL_W'(DECAY);

  logic                frame_tick;
  meter_state_e        state_q, state_d;
  logic [PEAK_W-1:0]   mag_d, mag_q;
  logic                mag_vld_q;
  logic [PEAK_W-1:0]   peak_q, peak_d;
  logic                clip_acc_q, clip_acc_d;
  logic [PEAK_W-1:0]   hold_q, hold_d;
  logic                hold_clip_q, hold_clip_d;
  logic [LEVEL_W-1:0]  scaled_q, scaled_d;
  logic [LEVEL_W-1:0]  level_q, level_d;
  logic                level_stb_q, level_stb_d;
  logic                clip_q, clip_d;
  logic [LEVEL_W-1:0]  cand;

  sync_edge_det #(.N(SYNC_STAGES)) u_vsync_det (
    .clk_i  (clk_sys),
    .rst_ni (reset_n),
    .d_i    (vsync),
    .fall_o (frame_tick)
  );

  // Saturating absolute value. Negation uses only the low 15 bits: for any
  // negative sample other than 0x8000 the true magnitude fits in 15 bits.
  always_comb begin
    if (sample_in == 16'h8000) mag_d = FULL_SCALE;
    else if (sample_in[15])    mag_d = ~sample_in[14:0] + 15'd1;
    else                       mag_d = sample_in[14:0];
  end

  always_comb begin
    state_d     = state_q;
    peak_d      = peak_q;
    clip_acc_d  = clip_acc_q;
    hold_d      = hold_q;
    hold_clip_d = hold_clip_q;
    scaled_d    = scaled_q;
    level_d     = level_q;
    clip_d      = clip_q;
    level_stb_d = 1'b0;
    cand        = '0;

    // Accumulation runs in every state so samples during SCALE/DECAY land in
    // the new frame.
    if (mag_vld_q) begin
      if (mag_q > peak_q)       peak_d     = mag_q;
      if (mag_q == FULL_SCALE)  clip_acc_d = 1'b1;
    end

    case (state_q)
      ST_ACCUM: begin
        if (frame_tick) begin
          hold_d      = peak_q;
          hold_clip_d = clip_acc_q;
          // A magnitude arriving with the tick seeds the new frame.
          peak_d      = mag_vld_q ? mag_q : '0;
          clip_acc_d  = mag_vld_q && (mag_q == FULL_SCALE);
          state_d     = ST_SCALE;
        end
      end
      ST_SCALE: begin
        scaled_d = scale_sat(hold_q, SHIFT);
        state_d  = ST_DECAY;
      end
      ST_DECAY: begin
        cand        = (level_q > DECAY_L) ? level_q - DECAY_L : '0;
        level_d     = (en && (scaled_q > cand)) ? scaled_q : cand;
        clip_d      = en & hold_clip_q;
        level_stb_d = 1'b1;
        state_d     = ST_ACCUM;
      end
      default: state_d = ST_ACCUM;
    endcase
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_ACCUM;
      mag_q       <= '0;
      mag_vld_q   <= 1'b0;
      peak_q      <= '0;
      clip_acc_q  <= 1'b0;
      hold_q      <= '0;
      hold_clip_q <= 1'b0;
      scaled_q    <= '0;
      level_q     <= '0;
      level_stb_q <= 1'b0;
      clip_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      if (sample_stb) mag_q <= mag_d;
      mag_vld_q   <= sample_stb;
      peak_q      <= peak_d;
      clip_acc_q  <= clip_acc_d;
      hold_q      <= hold_d;
      hold_clip_q <= hold_clip_d;
      scaled_q    <= scaled_d;
      level_q     <= level_d;
      level_stb_q <= level_stb_d;
      clip_q      <= clip_d;
    end
  end

  assign level     = level_q;
  assign level_stb = level_stb_q;
  assign clip      = clip_q;

endmodule

// File: tb/tb_audio_level_meter.sv
module tb_audio_level_meter;

  localparam int SHIFT       = 7;
  localparam int DECAY       = 2;
  localparam int SYNC_STAGES = 2;

  logic        clk_sys    = 1'b0;
  logic        reset_n    = 1'b0;
  logic [15:0] sample_in  = 16'h0000;
  logic        sample_stb = 1'b0;
  logic        vsync      = 1'b1;
  logic        en         = 1'b1;
  logic [7:0]  level;
  logic        level_stb;
  logic        clip;

  always #5 clk_sys = ~clk_sys;

  audio_level_meter #(
    .SHIFT       (SHIFT),
    .DECAY       (DECAY),
    .SYNC_STAGES (SYNC_STAGES)
  ) dut (
    .clk_sys    (clk_sys),
    .reset_n    (reset_n),
    .sample_in  (sample_in),
    .sample_stb (sample_stb),
    .vsync      (vsync),
    .en         (en),
    .level      (level),
    .level_stb  (level_stb),
    .clip       (clip)
  );

  int passed    = 0;
  int total     = 0;
  int stb_count = 0;

  always @(posedge clk_sys) if (level_stb) stb_count <= stb_count + 1;

  // Scoreboard: {clip, level} expected for each vsync fall, in order.
  logic [8:0] exp_q[$];

  // Reference meter state, advanced as stimulus is driven.
  int model_level = 0;
  int frame_peak  = 0;
  bit frame_clip  = 1'b0;

  function automatic int tb_mag(input logic [15:0] s);
    int v;
    v = int'($signed(s));
    if (v < 0) v = -v;
    if (v > 32767) v = 32767;
    return v;
  endfunction

  task automatic send_sample(input logic [15:0] s);
    int m;
    m = tb_mag(s);
    @(posedge clk_sys); #1;
    sample_in  = s;
    sample_stb = 1'b1;
    @(posedge clk_sys); #1;
    sample_stb = 1'b0;
    if (m > frame_peak) frame_peak = m;
    if (m == 32767) frame_clip = 1'b1;
  endtask

  task automatic push_expected();
    int sc, cand, nl;
    sc = frame_peak >> SHIFT;
    if (sc > 255) sc = 255;
    cand = (model_level > DECAY) ? model_level - DECAY : 0;
    nl = en ? ((sc > cand) ? sc : cand) : cand;
    exp_q.push_back({(en & frame_clip), 8'(nl)});
    model_level = nl;
    frame_peak  = 0;
    frame_clip  = 1'b0;
  endtask

  // Drops vsync, optionally injects one sample timed so its magnitude is
  // registered in the frame_tick cycle, then checks the resulting update.
  task automatic run_frame(input string name, input bit bnd, input logic [15:0] bnd_val);
    int cnt, start, m;
    bit seen;
    logic [8:0] exp_v;
    push_expected();
    if (bnd) begin
      m = tb_mag(bnd_val);
      frame_peak = m;
      frame_clip = (m == 32767);
    end
    start = stb_count;
    cnt   = 0;
    seen  = 1'b0;
    @(posedge clk_sys); #1;
    vsync = 1'b0;
    while (!seen && cnt < 20) begin
      @(posedge clk_sys); #1;
      cnt++;
      if (bnd && cnt == 2) begin
        sample_in  = bnd_val;
        sample_stb = 1'b1;
      end
      if (bnd && cnt == 3) sample_stb = 1'b0;
      if (level_stb) seen = 1'b1;
    end
    exp_v = exp_q.pop_front();

    total++;
    if (cnt !== SYNC_STAGES + 4)
      $display("FAIL %s latency: got %0d cycles, expected %0d", name, cnt, SYNC_STAGES + 4);
    else passed++;

    total++;
    if (level !== exp_v[7:0])
      $display("FAIL %s level: got %02h, expected %02h", name, level, exp_v[7:0]);
    else passed++;

    total++;
    if (clip !== exp_v[8])
      $display("FAIL %s clip: got %0b, expected %0b", name, clip, exp_v[8]);
    else passed++;

    $display("frame %s: level=%02h clip=%0b after %0d cycles", name, level, clip, cnt);

    @(posedge clk_sys); #1;
    total++;
    if (level_stb !== 1'b0)
      $display("FAIL %s stb_width: got level_stb=%0b one cycle later, expected 0", name, level_stb);
    else passed++;

    total++;
    if (stb_count !== start + 1)
      $display("FAIL %s stb_count: got %0d pulses, expected 1", name, stb_count - start);
    else passed++;

    vsync = 1'b1;
    repeat (8) @(posedge clk_sys);
  endtask

  task automatic test_reset();
    #2;
    total++;
    if (level !== 8'h00) $display("FAIL reset level: got %02h, expected 00", level);
    else passed++;
    total++;
    if (level_stb !== 1'b0) $display("FAIL reset level_stb: got %0b, expected 0", level_stb);
    else passed++;
    total++;
    if (clip !== 1'b0) $display("FAIL reset clip: got %0b, expected 0", clip);
    else passed++;
    repeat (3) @(posedge clk_sys);
    #1 reset_n = 1'b1;
    repeat (10) @(posedge clk_sys);
    #1;
    total++;
    if (stb_count !== 0) $display("FAIL reset no_update: got %0d pulses, expected 0", stb_count);
    else passed++;
    $display("reset: level=%02h clip=%0b pulses=%0d", level, clip, stb_count);
  endtask

  task automatic test_decay();
    send_sample(16'h0280);               // 0x280 >> 7 = 5
    run_frame("decay_load", 1'b0, 16'h0);
    run_frame("decay_1", 1'b0, 16'h0);   // 3
    run_frame("decay_2", 1'b0, 16'h0);   // 1
    run_frame("decay_3", 1'b0, 16'h0);   // 0
    run_frame("decay_4", 1'b0, 16'h0);   // stays 0
  endtask

  task automatic test_steady_tone();
    send_sample(16'h2000);
    send_sample(16'hE000);
    send_sample(16'h1FFF);
    send_sample(16'hE001);
    run_frame("tone", 1'b0, 16'h0);      // 0x40
  endtask

  task automatic test_boundary();
    run_frame("bnd_edge", 1'b1, 16'h7000); // excluded: 0x40 decays to 0x3E
    run_frame("bnd_next", 1'b0, 16'h0);    // 0x7000 >> 7 = 0xE0
  endtask

  task automatic test_saturation();
    send_sample(16'h1000);
    send_sample(16'h8000);
    run_frame("sat_clip", 1'b0, 16'h0);  // 0xFF, clip
    run_frame("sat_quiet", 1'b0, 16'h0); // 0xFD, no clip
    send_sample(16'h7FFF);
    run_frame("sat_pos", 1'b0, 16'h0);   // 0xFF, clip
  endtask

  task automatic test_reset_midframe();
    int start;
    @(posedge clk_sys); #1;
    sample_in  = 16'h4000;
    sample_stb = 1'b1;
    repeat (3) @(posedge clk_sys);
    #3 reset_n = 1'b0;
    #1;
    total++;
    if (level !== 8'h00) $display("FAIL midreset level: got %02h, expected 00", level);
    else passed++;
    total++;
    if (clip !== 1'b0) $display("FAIL midreset clip: got %0b, expected 0", clip);
    else passed++;
    total++;
    if (level_stb !== 1'b0) $display("FAIL midreset level_stb: got %0b, expected 0", level_stb);
    else passed++;
    $display("midreset: level=%02h clip=%0b", level, clip);
    sample_stb  = 1'b0;
    model_level = 0;
    frame_peak  = 0;
    frame_clip  = 1'b0;
    start = stb_count;
    repeat (3) @(posedge clk_sys);
    #1 reset_n = 1'b1;
    repeat (20) @(posedge clk_sys);
    #1;
    total++;
    if (stb_count !== start)
      $display("FAIL vsync_idle updates: got %0d pulses, expected 0", stb_count - start);
    else passed++;
    send_sample(16'h0800);
    run_frame("post_reset", 1'b0, 16'h0); // only 0x0800 counts: 0x10
  endtask

  task automatic test_enable();
    en = 1'b0;
    send_sample(16'h7FFF);
    send_sample(16'h8000);
    run_frame("en_off_1", 1'b0, 16'h0);  // 0x0E, no clip
    send_sample(16'h7FFF);
    run_frame("en_off_2", 1'b0, 16'h0);  // 0x0C, no clip
    en = 1'b1;
  endtask

  initial begin
    test_reset();
    test_decay();
    test_steady_tone();
    test_boundary();
    test_saturation();
    test_reset_midframe();
    test_enable();
    total++;
    if (exp_q.size() !== 0) $display("FAIL scoreboard: %0d entries left, expected 0", exp_q.size());
    else passed++;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
